// File: rtl/dual_diagonal_pkg.sv
// Shared types and constants for the dual-diagonal parity stages.
// The backsub and accumulate stages import the same vector length from here.
package dual_diagonal_pkg;

  // Default data word width in bits.
  localparam int DD_WIDTH     = 8;
  // Default number of words per vector, shared by the backsub and accumulate stages.
  localparam int DD_NUM_WORDS = 1024;
  // Number of entries held by the output register slice.
  localparam int SKID_DEPTH   = 2;

  // One skid entry at the default width. Modules built with another WIDTH
  // declare the same {data, last} layout locally from their own parameter.
  typedef struct packed {
    logic [DD_WIDTH-1:0] data;
    logic                last;
  } dd_entry_t;

  // Result of checking an accepted word against the vector boundary.
  typedef enum logic [1:0] {
    ALIGN_OK           = 2'd0,
    ALIGN_EARLY_LAST   = 2'd1,
    ALIGN_MISSING_LAST = 2'd2
  } align_status_t;

  // at_end: the word sits in the final slot of the vector.
  // last:   the upstream marked the word as the final one.
  function automatic align_status_t classify_boundary(input logic at_end, input logic last);
    align_status_t status;
    status = ALIGN_OK;
    if (last && !at_end) begin
      status = ALIGN_EARLY_LAST;
    end else if (at_end && !last) begin
      status = ALIGN_MISSING_LAST;
    end
    return status;
  endfunction

endpackage

// File: rtl/dd_skid_buffer.sv
// Two-entry valid/ready register slice in FIFO order.
// The output comes straight from a register, and the input ready is registered too,
// so no combinational path runs between the two sides.
module dd_skid_buffer
  import dual_diagonal_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SKID_DEPTH);

  // head_reg is the entry on the output. tail_reg holds the second entry while the slice is full.
  logic [DATA_W-1:0] head_reg;
  logic [DATA_W-1:0] tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              in_ready_reg;
  logic              in_fire;
  logic              out_fire;

  assign o_in_ready  = in_ready_reg;
  assign o_out_valid = (count_reg != '0);
  assign o_out_data  = head_reg;
  assign in_fire     = i_in_valid & in_ready_reg;
  assign out_fire    = o_out_valid & i_out_ready;

  // Occupancy bookkeeping. A push and a pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    if (in_fire && !out_fire) begin
      count_next = count_reg + CNT_ONE;
    end else if (out_fire && !in_fire) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Storage, occupancy and registered ready. Ready means there is room after this cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      in_ready_reg <= (count_next < CNT_FULL);
      if (out_fire) begin
        // Move the queue forward. A new word goes straight to the head only
        // when it would otherwise land behind an empty slot.
        if (in_fire && (count_reg == CNT_ONE)) begin
          head_reg <= i_in_data;
        end else begin
          head_reg <= tail_reg;
        end
        if (in_fire && (count_reg == CNT_FULL)) begin
          tail_reg <= i_in_data;
        end
      end else if (in_fire) begin
        if (count_reg == '0) begin
          head_reg <= i_in_data;
        end else begin
          tail_reg <= i_in_data;
        end
      end
    end
  end

endmodule

// File: rtl/dual_diagonal_accumulate.sv
// Recovers x[k] = y[k] ^ x[k-1] from back-substituted words, using a running XOR
// that clears at every vector boundary. The boundary is either the NUM_WORDS-th
// word or an upstream last flag. Any disagreement between the two is reported
// on o_align_error.
module dual_diagonal_accumulate
  import dual_diagonal_pkg::*;
#(
  parameter int WIDTH     = DD_WIDTH,
  parameter int NUM_WORDS = DD_NUM_WORDS   // must be >= 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready,
  output logic             o_align_error
);

  localparam int CW = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] CW_ONE   = CW'(1);

  // Skid entry at this instance's width: {recovered word, last-of-vector}.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } skid_entry_t;

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    word_count_reg;
  logic [CW-1:0]    word_count_next;
  logic             align_error_reg;
  logic             align_error_next;
  logic             in_fire;
  logic             at_end;
  logic             boundary;
  logic [WIDTH-1:0] x_word;
  align_status_t    align_status;
  skid_entry_t      push_entry;
  skid_entry_t      pop_entry;

  assign in_fire      = i_in_valid & o_in_ready;
  assign at_end       = (word_count_reg == LAST_IDX);
  assign boundary     = at_end | i_in_last;
  assign x_word       = acc_reg ^ i_in_data;
  assign align_status = classify_boundary(at_end, i_in_last);

  assign push_entry.data = x_word;
  assign push_entry.last = boundary;

  // Next accumulator, word position and alignment flag. All of them hold unless a word is accepted.
  always_comb begin
    acc_next         = acc_reg;
    word_count_next  = word_count_reg;
    align_error_next = 1'b0;
    if (in_fire) begin
      align_error_next = (align_status != ALIGN_OK);
      if (boundary) begin
        acc_next        = '0;
        word_count_next = '0;
      end else begin
        acc_next        = x_word;
        word_count_next = word_count_reg + CW_ONE;
      end
    end
  end

  // Accumulator, word counter and one-cycle alignment pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc_reg         <= '0;
      word_count_reg  <= '0;
      align_error_reg <= 1'b0;
    end else begin
      acc_reg         <= acc_next;
      word_count_reg  <= word_count_next;
      align_error_reg <= align_error_next;
    end
  end

  assign o_align_error = align_error_reg;

  dd_skid_buffer #(
    .DATA_W($bits(skid_entry_t))
  ) u_skid (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_in_data   (push_entry),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (pop_entry),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready)
  );

  assign o_out_data = pop_entry.data;
  assign o_out_last = pop_entry.last;

endmodule

// File: tb/tb_dual_diagonal_accumulate.sv
// Scoreboard bench for dual_diagonal_accumulate. A 4-word instance runs the
// directed and random alignment cases, and a 1024-word instance runs the
// backsub round trip.
module tb_dual_diagonal_accumulate;

  localparam int NW4 = 4;
  localparam int NWK = 1024;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // 4-word instance
  logic [7:0] in_data4, out_data4;
  logic in_valid4, in_last4, in_ready4, out_valid4, out_last4, out_ready4, align4;
  // 1024-word instance
  logic [7:0] in_data_k, out_data_k;
  logic in_valid_k, in_last_k, in_ready_k, out_valid_k, out_last_k, out_ready_k, align_k;

  dual_diagonal_accumulate #(.WIDTH(8), .NUM_WORDS(NW4)) dut4 (
    .i_clock(clock), .i_reset(reset),
    .i_in_data(in_data4), .i_in_valid(in_valid4), .i_in_last(in_last4), .o_in_ready(in_ready4),
    .o_out_data(out_data4), .o_out_valid(out_valid4), .o_out_last(out_last4),
    .i_out_ready(out_ready4), .o_align_error(align4));

  dual_diagonal_accumulate #(.WIDTH(8), .NUM_WORDS(NWK)) dutk (
    .i_clock(clock), .i_reset(reset),
    .i_in_data(in_data_k), .i_in_valid(in_valid_k), .i_in_last(in_last_k), .o_in_ready(in_ready_k),
    .o_out_data(out_data_k), .o_out_valid(out_valid_k), .o_out_last(out_last_k),
    .i_out_ready(out_ready_k), .o_align_error(align_k));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         t;
  } exp4_t;
  typedef struct {
    logic [7:0] data;
    logic       last;
  } expk_t;

  exp4_t      exp4[$];
  expk_t      expk[$];
  logic [7:0] vec4[$];   // y words of the vector currently entering dut4
  logic       err_pend4 = 1'b0;
  logic       lat4 = 1'b0;
  logic       stall4 = 1'b0;
  logic [7:0] stall_data4;
  logic       stall_last4;
  logic       rand4 = 1'b0, randk = 1'b0;
  exp4_t      e4, n4;
  expk_t      ek;
  logic [7:0] mx;
  logic       at_slot_end;

  always @(posedge clock) cyc <= cyc + 1;

  // dut4: monitor first, then the reference model for any word accepted this cycle.
  always @(negedge clock) begin
    if (reset) begin
      exp4.delete();
      vec4.delete();
      err_pend4 = 1'b0;
      stall4    = 1'b0;
    end else begin
      check("align_error4", align4, err_pend4);
      if (stall4) begin
        check("hold_valid4", out_valid4, 1'b1);
        check("hold_data4", out_data4, stall_data4);
        check("hold_last4", out_last4, stall_last4);
      end
      if (out_valid4 && out_ready4) begin
        if (exp4.size() == 0) begin
          checks++; errors++;
          $display("FAIL out4_extra actual=%0h required=none", out_data4);
        end else begin
          e4 = exp4.pop_front();
          $display("dut4 out data=%02h last=%0d", out_data4, out_last4);
          check("out_data4", out_data4, e4.data);
          check("out_last4", out_last4, e4.last);
          if (lat4) check("latency4", cyc - e4.t, 1);
        end
      end
      stall4      = out_valid4 && !out_ready4;
      stall_data4 = out_data4;
      stall_last4 = out_last4;
      // Reference: x is the XOR of every y received so far in this vector, including this one.
      err_pend4 = 1'b0;
      if (in_valid4 && in_ready4) begin
        mx = in_data4;
        foreach (vec4[i]) mx = mx ^ vec4[i];
        at_slot_end = (vec4.size() == NW4 - 1);
        err_pend4   = (in_last4 && !at_slot_end) || (at_slot_end && !in_last4);
        n4.data = mx;
        n4.last = at_slot_end || in_last4;
        n4.t    = cyc;
        exp4.push_back(n4);
        if (n4.last) vec4.delete();
        else         vec4.push_back(in_data4);
      end
    end
  end

  // dutk: every output must equal the original pre-backsub vector word.
  always @(negedge clock) begin
    if (reset) begin
      expk.delete();
    end else if (out_valid_k && out_ready_k) begin
      if (expk.size() == 0) begin
        checks++; errors++;
        $display("FAIL outk_extra actual=%0h required=none", out_data_k);
      end else begin
        ek = expk.pop_front();
        check("out_data_k", out_data_k, ek.data);
        check("out_last_k", out_last_k, ek.last);
        check("align_k", align_k, 1'b0);
      end
    end
  end

  // Random downstream backpressure for whichever instance has it enabled.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand4) out_ready4  = 1'($urandom_range(0, 1));
      if (randk) out_ready_k = 1'($urandom_range(0, 1));
    end
  end

  // Present a word to dut4 and hold it until it is accepted. Called and returns at posedge+1.
  task automatic send4(input logic [7:0] y, input logic last);
    int n = 0;
    in_data4 = y; in_last4 = last; in_valid4 = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready4 && n < 200);
    if (!in_ready4) begin
      checks++; errors++;
      $display("FAIL send4_timeout actual=no_accept required=accept y=%02h", y);
    end
    $display("dut4 in  data=%02h last=%0d", y, last);
    @(posedge clock); #1;
    in_valid4 = 1'b0; in_last4 = 1'b0;
  endtask

  task automatic send_k(input logic [7:0] y, input logic last);
    int n = 0;
    in_data_k = y; in_last_k = last; in_valid_k = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready_k && n < 200);
    if (!in_ready_k) begin
      checks++; errors++;
      $display("FAIL sendk_timeout actual=no_accept required=accept y=%02h", y);
    end
    @(posedge clock); #1;
    in_valid_k = 1'b0; in_last_k = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [7:0] xw, prev;
  int drain;

  initial begin
    reset = 1'b1;
    in_data4 = '0; in_valid4 = 1'b0; in_last4 = 1'b0; out_ready4 = 1'b1;
    in_data_k = '0; in_valid_k = 1'b0; in_last_k = 1'b0; out_ready_k = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready4, 1'b0);
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_out_data", out_data4, 8'h00);
    check("rst_out_last", out_last4, 1'b0);
    check("rst_align", align4, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);
    check("ready_after_reset", in_ready4, 1'b1);

    // Basic vector, then boundary clear, back to back, with single-cycle latency.
    lat4 = 1'b1;
    send4(8'h01, 0); send4(8'h03, 0); send4(8'h07, 0); send4(8'h0F, 1);
    send4(8'h01, 0); send4(8'h01, 0); send4(8'h01, 0); send4(8'h01, 1);
    idle(3);
    lat4 = 1'b0;

    // Backpressure: the slice fills after two accepts and the head word holds.
    out_ready4 = 1'b0;
    fork
      begin
        send4(8'h01, 0); send4(8'h03, 0); send4(8'h07, 0); send4(8'h0F, 1);
      end
      begin
        repeat (3) @(negedge clock);
        check("bp_in_ready_low", in_ready4, 1'b0);
        check("bp_out_valid", out_valid4, 1'b1);
        check("bp_head_data", out_data4, 8'h01);
        repeat (3) @(posedge clock);
        #1 out_ready4 = 1'b1;
      end
    join
    idle(4);

    // Early last, then resynchronised vector.
    send4(8'h10, 0); send4(8'h30, 1);
    send4(8'h05, 0); send4(8'h00, 0); send4(8'h00, 0); send4(8'h00, 1);
    idle(3);

    // Missing last, then the next vector starts from zero.
    send4(8'h11, 0); send4(8'h22, 0); send4(8'h44, 0); send4(8'h88, 0);
    send4(8'h33, 0); send4(8'h01, 0); send4(8'h02, 0); send4(8'h04, 1);
    idle(3);

    // Random words, random last flags, random gaps and random backpressure.
    rand4 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send4(8'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand4 = 1'b0;
    out_ready4 = 1'b1;
    idle(6);

    // Reset mid-vector with one word stalled in the slice.
    send4(8'h0A, 0);
    idle(1);
    out_ready4 = 1'b0;
    send4(8'h0B, 0);
    @(negedge clock);
    check("stalled_present", out_valid4, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid4, 1'b0);
    check("midrst_out_data", out_data4, 8'h00);
    check("midrst_out_last", out_last4, 1'b0);
    check("midrst_in_ready", in_ready4, 1'b0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready4 = 1'b1;
    idle(1);
    send4(8'h07, 0); send4(8'h01, 0); send4(8'h02, 0); send4(8'h04, 1);
    idle(4);

    // Round trip through a backsub model into the 1024-word instance.
    randk = 1'b1;
    for (int v = 0; v < 3; v++) begin
      prev = 8'h00;
      for (int k = 0; k < NWK; k++) begin
        xw = 8'($urandom);
        expk.push_back('{data: xw, last: (k == NWK - 1)});
        send_k(xw ^ prev, (k == NWK - 1));
        prev = xw;
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      $display("dutk vector %0d sent", v);
    end
    drain = 0;
    while ((expk.size() != 0 || exp4.size() != 0) && drain < 20000) begin
      idle(1);
      drain++;
    end
    randk = 1'b0;
    check("drain_exp4", exp4.size(), 0);
    check("drain_expk", expk.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_diagonal_accumulate.md
Name: dual_diagonal_accumulate

Overview:
- Inverse of the dual-diagonal back-substitution stage in the LDPC parity datapath.
- Each input word is y[k] = x[k] ^ x[k-1] within a vector. This block recovers x[k] = y[k] ^ x[k-1] with a running XOR accumulator.
- The accumulator clears at every NUM_WORDS-word vector boundary.
- Sits on the decode/verification side. Uses valid/ready handshakes on both ports and a 2-entry output skid buffer, so downstream stalls lose no data.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_WORDS, 1024, words per vector. Must be >= 2.

Ports:
- i_clock  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_in_data  in  WIDTH  back-substituted word y[k].
- i_in_valid  in  1  input word present.
- i_in_last  in  1  marks the final word of a vector; qualified by accept.
- o_in_ready  out  1  block can accept an input word.
- o_out_data  out  WIDTH  recovered word x[k].
- o_out_valid  out  1  output word present.
- o_out_last  out  1  final word of the recovered vector.
- i_out_ready  in  1  downstream accepts the output word.
- o_align_error  out  1  one-cycle pulse on a vector-boundary mismatch.

Behaviour:
- Reset (async assert, sync deassert by design convention):
  - word_count = 0, acc = 0, skid empty.
  - o_out_valid = 0, o_out_data = 0, o_out_last = 0, o_align_error = 0.
  - o_in_ready = 0 while i_reset is high, and 1 in the first cycle after release.
- Accept: in_fire = i_in_valid & o_in_ready. Output fire: out_fire = o_out_valid & i_out_ready.
- On in_fire, compute x = acc ^ i_in_data, using full WIDTH with no carry.
  - Push {x, last_flag} into the skid buffer.
  - boundary = (word_count == NUM_WORDS-1) | i_in_last.
  - If boundary: acc <= 0, word_count <= 0, last_flag = 1.
  - Otherwise: acc <= x, word_count <= word_count + 1, last_flag = 0.
- Alignment checking, evaluated on in_fire only:
  - i_in_last = 1 with word_count != NUM_WORDS-1: early last. Pulse o_align_error, resynchronise (count and acc cleared as above).
  - word_count == NUM_WORDS-1 with i_in_last = 0: missing last. Pulse o_align_error, wrap anyway.
  - o_align_error is registered: it is high in the cycle after the offending accept, for exactly 1 cycle.
- Latency: an accepted word appears on o_out_data/o_out_valid in the next cycle when the skid is empty. Throughput is 1 word/cycle while i_out_ready = 1.
- Skid buffer, 2 entries, FIFO order:
  - o_in_ready = (occupancy < 2), registered.
  - Simultaneous in_fire and out_fire: occupancy unchanged and order preserved.
  - Full: o_in_ready = 0, so input is held off and nothing is dropped or overwritten.
  - o_out_data, o_out_last and o_out_valid hold stable while o_out_valid = 1 and i_out_ready = 0.
- Input words presented while o_in_ready = 0 are not consumed, and acc and word_count are unchanged.
- Reset mid-vector: the partial vector and any buffered words are discarded. The next accepted word is word 0 of a new vector.
- word_count width is $clog2(NUM_WORDS). Wrap is explicit, not by overflow.

Decomposition:
- Package dual_diagonal_pkg holds:
  - typedef for the {data, last} skid entry, parameterised via the module;
  - localparam SKID_DEPTH = 2;
  - the shared NUM_WORDS default, so the backsub and accumulate stages agree on vector length.
- Sub-module dd_skid_buffer: generic 2-entry valid/ready register slice with async active-high reset.
- The top module contains only the accumulator, counter and alignment logic.

Test Plan (WIDTH=8, NUM_WORDS=4 unless noted):
- Basic vector: y = 0x01,0x03,0x07,0x0F, i_in_last on the 4th word, i_out_ready = 1 -> x = 0x01,0x02,0x05,0x0A, each 1 cycle after accept. o_out_last on 0x0A only. o_align_error never asserts.
- Boundary clear: a second vector y = 0x01,0x01,0x01,0x01 immediately follows -> x = 0x01,0x00,0x01,0x00. The accumulator does not carry over from vector 1.
- Backpressure: drive 4 words back to back while holding i_out_ready = 0 for 6 cycles, then release -> o_in_ready drops after 2 accepts. Output data holds 0x01 while stalled. All 4 words arrive in order (0x01,0x02,0x05,0x0A) with no loss or duplication.
- Early last: y = 0x10,0x30 with i_in_last on 0x30 -> x = 0x10,0x20 with o_out_last on 0x20, and a 1-cycle o_align_error. Next word 0x05 -> x = 0x05 (resynchronised).
- Missing last: 4 words without i_in_last -> 1-cycle o_align_error after the 4th accept, o_out_last still set on the 4th word, and the 5th word starts from acc = 0.
- Reset mid-vector, plus round trip: assert i_reset after 2 accepts with 1 word stalled in the skid -> outputs go to 0 immediately and the stalled word is discarded. Then run random 1024-word vectors through the back-substitution stage followed by this block (NUM_WORDS=1024) -> the output equals the original vectors bit for bit under random i_out_ready.
